// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result bundle between the operand registers, the nibble-serial adder and the display.
// The master drives operands and start; the slave (the adder) returns status and result.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             v;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, v
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, v
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit carry-select slice reused WIDTH/4 times,
// LSB nibble first, with start/busy/done handshake and carry/overflow flags at completion.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result layout: [5] carry into bit 3, [4] carry out, [3:0] nibble sum.
    // Low two bits ripple; the high pair is precomputed for both carries and selected.
    function automatic logic [5:0] nib_csa(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic       c1;
        logic       c2;
        logic       c3_0;
        logic       c3_1;
        logic       c4_0;
        logic       c4_1;
        logic [1:0] lo;
        logic [1:0] hi0;
        logic [1:0] hi1;
        lo[0]  = x[0] ^ y[0] ^ c0;
        c1     = (x[0] & y[0]) | (c0 & (x[0] ^ y[0]));
        lo[1]  = x[1] ^ y[1] ^ c1;
        c2     = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));
        hi0[0] = x[2] ^ y[2];
        c3_0   = x[2] & y[2];
        hi0[1] = x[3] ^ y[3] ^ c3_0;
        c4_0   = (x[3] & y[3]) | (c3_0 & (x[3] ^ y[3]));
        hi1[0] = ~(x[2] ^ y[2]);
        c3_1   = x[2] | y[2];
        hi1[1] = x[3] ^ y[3] ^ c3_1;
        c4_1   = (x[3] & y[3]) | (c3_1 & (x[3] ^ y[3]));
        return c2 ? {c3_1, c4_1, hi1, lo} : {c3_0, c4_0, hi0, lo};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic               accept_s;
    logic               last_s;
    logic [IDXW-1:0]    idx_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [WIDTH-1:0]   shadow_r;
    logic [WIDTH-1:0]   shadow_next_s;
    logic [3:0]         nib_a_s;
    logic [3:0]         nib_b_s;
    logic [5:0]         nib_res_s;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               v_r;
    logic               busy_r;
    logic               done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; start is only honoured outside RUN.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == IDX_LAST) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Nibble select, slice add and shadow-result merge for the current step.
    always_comb begin
        nib_a_s       = 4'h0;
        nib_b_s       = 4'h0;
        shadow_next_s = shadow_r;
        for (int n = 0; n < NIB; n++) begin
            nib_a_s = (idx_r == IDXW'(n)) ? a_r[4*n +: 4] : nib_a_s;
            nib_b_s = (idx_r == IDXW'(n)) ? b_r[4*n +: 4] : nib_b_s;
        end
        nib_res_s = nib_csa(nib_a_s, nib_b_s, carry_r);
        for (int n = 0; n < NIB; n++) begin
            shadow_next_s[4*n +: 4] = (idx_r == IDXW'(n)) ? nib_res_s[3:0] : shadow_r[4*n +: 4];
        end
    end

    // Operand capture, per-step carry/shadow update, and result publish on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r    <= {IDXW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            shadow_r <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            v_r      <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= {IDXW{1'b0}};
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
        end else if (state_r == RUN) begin
            idx_r    <= idx_r + IDXW'(1);
            carry_r  <= nib_res_s[4];
            shadow_r <= shadow_next_s;
            if (last_s) begin
                sum_r  <= shadow_next_s;
                cout_r <= nib_res_s[4];
                v_r    <= nib_res_s[5] ^ nib_res_s[4];
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
                v_r    <= v_r;
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.v    = v_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16): hand-computed sums, flags,
// handshake timing, start-during-RUN / start-held-in-DONE, and reset abort.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input logic sb, input logic [WIDTH-1:0] es,
                          input logic ec, input logic ev);
        logic [WIDTH-1:0] prev;
        prev      = bus.sum;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        bus.sub   = sb;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= NIB; k++) begin
            if (k > 1) @(negedge clk);
            check({tag, "/busy"}, 32'(bus.busy), 32'd1);
            check({tag, "/nodone"}, 32'(bus.done), 32'd0);
            check({tag, "/sumheld"}, 32'(bus.sum), 32'(prev));
        end
        @(negedge clk);
        check({tag, "/done"}, 32'(bus.done), 32'd1);
        check({tag, "/notbusy"}, 32'(bus.busy), 32'd0);
        check({tag, "/sum"}, 32'(bus.sum), 32'(es));
        check({tag, "/cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "/v"}, 32'(bus.v), 32'(ev));
        @(negedge clk);
        check({tag, "/idle_done"}, 32'(bus.done), 32'd0);
        check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/sum", 32'(bus.sum), 32'd0);
        check("rst/cout", 32'(bus.cout), 32'd0);
        check("rst/v", 32'(bus.v), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add000F", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        run_op("add0FFF", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("add7FFF", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("addFFFFc", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub8000m1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("addmix", 16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);

        // start pulsed with new operands mid-RUN must be ignored
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'h0F0F; bus.b = 16'h0101; bus.sub = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("runign/busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("runign/done", 32'(bus.done), 32'd1);
        check("runign/sum", 32'(bus.sum), 32'h3333);
        @(negedge clk);
        check("runign/idle", 32'(bus.busy), 32'd0);

        // start held through RUN and DONE: back-to-back operation
        bus.a = 16'h0100; bus.b = 16'h0200; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 16'h0A0A; bus.b = 16'h0505;
        repeat (NIB) @(negedge clk);
        check("held/done", 32'(bus.done), 32'd1);
        check("held/sum1", 32'(bus.sum), 32'h0300);
        @(negedge clk);
        bus.start = 1'b0;
        check("held/rebusy", 32'(bus.busy), 32'd1);
        check("held/redone", 32'(bus.done), 32'd0);
        repeat (NIB) @(negedge clk);
        check("held/done2", 32'(bus.done), 32'd1);
        check("held/sum2", 32'(bus.sum), 32'h0F0F);
        @(negedge clk);

        // reset during RUN at idx=2 aborts with no partial result or done pulse
        bus.a = 16'h2222; bus.b = 16'h1111; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort/busy", 32'(bus.busy), 32'd0);
        check("abort/done", 32'(bus.done), 32'd0);
        check("abort/sum", 32'(bus.sum), 32'd0);
        check("abort/cout", 32'(bus.cout), 32'd0);
        check("abort/v", 32'(bus.v), 32'd0);
        for (int k = 0; k < NIB + 2; k++) begin
            @(negedge clk);
            check("abort/nodone", 32'(bus.done), 32'd0);
            check("abort/nobusy", 32'(bus.busy), 32'd0);
        end

        run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
